// File: rtl/spi_pkg.sv
// Shared constants and SPI mode decode for the SPI peripheral slice.
package spi_pkg;

  localparam int unsigned BIT_CNT_W         = 3;
  localparam logic [7:0]  DEFAULT_FILL_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  function automatic logic spi_cpol(input int unsigned mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic spi_cpha(input int unsigned mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizes the async SPI pins into clk and emits registered SCLK lead/trail
// and CS_N fall/rise pulses, time-aligned with the synchronized MOSI.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter logic CPOL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sclk_lead,
  output logic sclk_trail,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_sync
);

  logic [2:0] sclk_q;
  logic [2:0] cs_n_q;
  logic [2:0] mosi_q;
  logic       sclk_rise;
  logic       sclk_fall;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign mosi_sync = mosi_q[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q     <= {3{CPOL}};
      // Reset CS as asserted so a master still holding CS_N low is not seen as a new fall.
      cs_n_q     <= '0;
      mosi_q     <= '0;
      sclk_lead  <= 1'b0;
      sclk_trail <= 1'b0;
      cs_fall    <= 1'b0;
      cs_rise    <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[1:0], spi_clk};
      cs_n_q     <= {cs_n_q[1:0], spi_cs_n};
      mosi_q     <= {mosi_q[1:0], spi_mosi};
      sclk_lead  <= CPOL ? sclk_fall : sclk_rise;
      sclk_trail <= CPOL ? sclk_rise : sclk_fall;
      cs_fall    <= ~cs_n_q[1] & cs_n_q[2];
      cs_rise    <= cs_n_q[1] & ~cs_n_q[2];
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled pins, one-byte TX holding register, RX/TX shift registers
// and an IDLE/ACTIVE framing FSM driven by chip select.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE  = 0,
  parameter logic [7:0]  FILL_BYTE = DEFAULT_FILL_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_dv,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_dv,
  output logic       busy,
  output logic       tx_underrun,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);

  spi_state_e           state;
  logic                 sclk_lead, sclk_trail, cs_fall, cs_rise, mosi_sync;
  logic                 sample_edge, shift_edge;
  logic [7:0]           hold_byte;
  logic                 hold_full;
  logic [7:0]           tx_shift, tx_shift_nxt, load_byte;
  logic [6:0]           rx_shift;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 byte_end;
  logic                 load_pt, load_bypass, load_fill;

  spi_slave_sync #(.CPOL(CPOL)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .sclk_lead (sclk_lead),
    .sclk_trail(sclk_trail),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_sync (mosi_sync)
  );

  assign sample_edge = CPHA ? sclk_trail : sclk_lead;
  assign shift_edge  = CPHA ? sclk_lead  : sclk_trail;
  assign busy        = (state == ST_ACTIVE);
  assign spi_miso_oe = busy;
  assign tx_ready    = ~hold_full;

  always_comb begin
    load_pt = 1'b0;
    if (state == ST_IDLE)
      load_pt = cs_fall;
    else if (!cs_rise)
      load_pt = CPHA ? (sample_edge && bit_cnt == '0) : (shift_edge && byte_end);
    load_bypass = load_pt && !hold_full && tx_dv;
    load_fill   = load_pt && !hold_full && !tx_dv;
    if (hold_full)  load_byte = hold_byte;
    else if (tx_dv) load_byte = tx_byte;
    else            load_byte = FILL_BYTE;
    tx_shift_nxt = tx_shift;
    if (load_pt)
      tx_shift_nxt = load_byte;
    else if (state == ST_ACTIVE && !cs_rise && shift_edge)
      tx_shift_nxt = {tx_shift[6:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_byte   <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '1;
      byte_end    <= 1'b0;
      rx_byte     <= '0;
      rx_dv       <= 1'b0;
      tx_underrun <= 1'b0;
      spi_miso    <= 1'b0;
    end else begin
      rx_dv       <= 1'b0;
      tx_underrun <= load_fill;
      tx_shift    <= tx_shift_nxt;

      if (load_pt && hold_full) begin
        hold_full <= 1'b0;
      end else if (tx_dv && !hold_full && !load_bypass) begin
        hold_byte <= tx_byte;
        hold_full <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state    <= ST_ACTIVE;
            bit_cnt  <= '1;
            byte_end <= 1'b0;
            rx_shift <= '0;
            if (!CPHA) spi_miso <= tx_shift_nxt[7];
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= '1;
            byte_end <= 1'b0;
            rx_shift <= '0;
            tx_shift <= '0;
            spi_miso <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[5:0], mosi_sync};
              bit_cnt  <= bit_cnt - BIT_CNT_W'(1);
              if (bit_cnt == '0) begin
                rx_byte <= {rx_shift, mosi_sync};
                rx_dv   <= 1'b1;
              end
            end
            // CPHA=0 reloads on the shift edge after the last sample, so remember that sample.
            if (!CPHA) begin
              spi_miso <= tx_shift_nxt[7];
              if (sample_edge && bit_cnt == '0) byte_end <= 1'b1;
              else if (shift_edge)              byte_end <= 1'b0;
            end else if (shift_edge) begin
              spi_miso <= tx_shift[7];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 and a mode-3 instance driven by a
// behavioural SPI master at clk/8, with table-driven transfers plus corner sequences.
module tb_spi_slave;

  logic clk, rst;
  logic sel;
  int unsigned cur_mode;
  logic m_clk, m_cs_n, m_mosi;
  logic tx_dv;
  logic [7:0] tx_byte;

  logic tx_dv0, tx_ready0, rx_dv0, busy0, und0, sclk0, cs0, miso0, oe0;
  logic tx_dv3, tx_ready3, rx_dv3, busy3, und3, sclk3, cs3, miso3, oe3;
  logic [7:0] rx_byte0, rx_byte3;

  logic s_rx_dv, s_und, s_busy, s_miso, s_oe, s_tx_ready;
  logic [7:0] s_rx_byte;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int und_cnt = 0;
  logic [7:0] rx_log [16];

  assign sclk0  = sel ? 1'b0 : m_clk;
  assign cs0    = sel ? 1'b1 : m_cs_n;
  assign tx_dv0 = sel ? 1'b0 : tx_dv;
  assign sclk3  = sel ? m_clk : 1'b1;
  assign cs3    = sel ? m_cs_n : 1'b1;
  assign tx_dv3 = sel ? tx_dv : 1'b0;

  assign s_rx_dv    = sel ? rx_dv3    : rx_dv0;
  assign s_und      = sel ? und3      : und0;
  assign s_busy     = sel ? busy3     : busy0;
  assign s_miso     = sel ? miso3     : miso0;
  assign s_oe       = sel ? oe3       : oe0;
  assign s_tx_ready = sel ? tx_ready3 : tx_ready0;
  assign s_rx_byte  = sel ? rx_byte3  : rx_byte0;

  spi_slave #(.SPI_MODE(0), .FILL_BYTE(8'hFF)) dut0 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_dv(tx_dv0), .tx_ready(tx_ready0),
    .rx_byte(rx_byte0), .rx_dv(rx_dv0), .busy(busy0), .tx_underrun(und0),
    .spi_clk(sclk0), .spi_cs_n(cs0), .spi_mosi(m_mosi), .spi_miso(miso0), .spi_miso_oe(oe0)
  );

  spi_slave #(.SPI_MODE(3), .FILL_BYTE(8'hFF)) dut3 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_dv(tx_dv3), .tx_ready(tx_ready3),
    .rx_byte(rx_byte3), .rx_dv(rx_dv3), .busy(busy3), .tx_underrun(und3),
    .spi_clk(sclk3), .spi_cs_n(cs3), .spi_mosi(m_mosi), .spi_miso(miso3), .spi_miso_oe(oe3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_rx_dv) begin
      rx_log[rx_cnt % 16] = s_rx_byte;
      rx_cnt = rx_cnt + 1;
    end
    if (s_und) und_cnt = und_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic half_bit();
    repeat (4) @(negedge clk);
  endtask

  task automatic set_mode(input int unsigned m);
    cur_mode = m;
    sel      = (m == 3);
    m_clk    = (m == 3);
    repeat (8) @(negedge clk);
  endtask

  task automatic tx_pulse(input logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    tx_dv   = 1'b1;
    @(negedge clk);
    tx_dv   = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    m_cs_n = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (12) @(negedge clk);
    m_cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (cur_mode == 3) m_clk = 1'b0;
      m_mosi = mo[i];
      half_bit();
      mi[i] = s_miso;
      m_clk = 1'b1;
      half_bit();
      if (cur_mode == 0) m_clk = 1'b0;
    end
  endtask

  typedef struct {
    int unsigned mode;
    logic        preload;
    logic [7:0]  tx;
    logic [7:0]  mosi;
    logic [7:0]  exp_miso;
    logic [7:0]  exp_rx;
    int          exp_und;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0] got, got2;
    int rx_base, und_base;

    vecs[0] = '{0, 1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 0};
    vecs[1] = '{0, 1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A, 1};
    vecs[2] = '{0, 1'b1, 8'h01, 8'hFF, 8'h01, 8'hFF, 0};
    vecs[3] = '{3, 1'b1, 8'h7E, 8'h81, 8'h7E, 8'h81, 0};
    vecs[4] = '{3, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 1};
    vecs[5] = '{3, 1'b1, 8'hC3, 8'h3C, 8'hC3, 8'h3C, 0};

    rst = 1'b1; sel = 1'b0; cur_mode = 0;
    m_clk = 1'b0; m_cs_n = 1'b1; m_mosi = 1'b0;
    tx_dv = 1'b0; tx_byte = '0;
    repeat (4) @(negedge clk);
    check("reset rx_byte0", rx_byte0, 8'h00);
    check("reset rx_dv0", rx_dv0, 1'b0);
    check("reset tx_ready0", tx_ready0, 1'b1);
    check("reset busy0", busy0, 1'b0);
    check("reset miso0", miso0, 1'b0);
    check("reset oe0", oe0, 1'b0);
    check("reset und0", und0, 1'b0);
    check("reset tx_ready3", tx_ready3, 1'b1);
    check("reset busy3", busy3, 1'b0);
    check("reset oe3", oe3, 1'b0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].mode != cur_mode) set_mode(vecs[i].mode);
      rx_base  = rx_cnt;
      und_base = und_cnt;
      if (vecs[i].preload) tx_pulse(vecs[i].tx);
      cs_low();
      check($sformatf("v%0d busy", i), s_busy, 1'b1);
      check($sformatf("v%0d oe", i), s_oe, 1'b1);
      tx_pulse(8'h00);
      xfer(vecs[i].mosi, 8, got);
      cs_high();
      check($sformatf("v%0d miso", i), got, vecs[i].exp_miso);
      check($sformatf("v%0d rx_dv count", i), rx_cnt - rx_base, 1);
      check($sformatf("v%0d rx_byte", i), rx_log[rx_base % 16], vecs[i].exp_rx);
      check($sformatf("v%0d underrun count", i), und_cnt - und_base, vecs[i].exp_und);
      check($sformatf("v%0d oe after cs", i), s_oe, 1'b0);
    end

    set_mode(0);

    // Two bytes in one CS window.
    rx_base = rx_cnt; und_base = und_cnt;
    tx_pulse(8'h11);
    cs_low();
    tx_pulse(8'h22);
    xfer(8'h12, 8, got);
    repeat (5) @(negedge clk);
    tx_pulse(8'h33);
    xfer(8'h34, 8, got2);
    cs_high();
    check("b2b miso byte1", got, 8'h11);
    check("b2b miso byte2", got2, 8'h22);
    check("b2b rx_dv count", rx_cnt - rx_base, 2);
    check("b2b rx byte1", rx_log[rx_base % 16], 8'h12);
    check("b2b rx byte2", rx_log[(rx_base + 1) % 16], 8'h34);
    check("b2b underrun count", und_cnt - und_base, 0);

    // CS abort after 5 bits, then a clean transfer.
    rx_base = rx_cnt;
    tx_pulse(8'hAA);
    cs_low();
    xfer(8'hF0, 5, got);
    cs_high();
    check("abort rx_dv count", rx_cnt - rx_base, 0);
    rx_base = rx_cnt;
    tx_pulse(8'h96);
    cs_low();
    tx_pulse(8'h00);
    xfer(8'hC7, 8, got);
    cs_high();
    check("post-abort miso", got, 8'h96);
    check("post-abort rx_dv count", rx_cnt - rx_base, 1);
    check("post-abort rx_byte", rx_log[rx_base % 16], 8'hC7);

    // tx_dv while holding is full is dropped.
    tx_pulse(8'h5C);
    check("hold full tx_ready", s_tx_ready, 1'b0);
    tx_pulse(8'hE1);
    check("dropped tx_ready", s_tx_ready, 1'b0);
    cs_low();
    tx_pulse(8'h00);
    xfer(8'h00, 8, got);
    cs_high();
    check("dropped tx_dv miso", got, 8'h5C);

    // Reset mid-byte with CS held low.
    tx_pulse(8'hFF);
    cs_low();
    xfer(8'h0F, 3, got);
    check("pre-reset miso", s_miso, 1'b1);
    rx_base = rx_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst rx_byte", s_rx_byte, 8'h00);
    check("mid rst rx_dv", s_rx_dv, 1'b0);
    check("mid rst tx_ready", s_tx_ready, 1'b1);
    check("mid rst busy", s_busy, 1'b0);
    check("mid rst miso", s_miso, 1'b0);
    check("mid rst oe", s_oe, 1'b0);
    check("mid rst underrun", s_und, 1'b0);
    xfer(8'hFF, 5, got);
    check("post rst busy", s_busy, 1'b0);
    check("post rst oe", s_oe, 1'b0);
    check("post rst rx_dv count", rx_cnt - rx_base, 0);
    cs_high();
    rx_base = rx_cnt;
    tx_pulse(8'h69);
    cs_low();
    tx_pulse(8'h00);
    xfer(8'h96, 8, got);
    cs_high();
    check("recover miso", got, 8'h69);
    check("recover rx_byte", rx_log[rx_base % 16], 8'h96);
    check("recover rx_dv count", rx_cnt - rx_base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
